// File: rtl/reaction_ms_timer.sv
// Reaction-time tester: derives a 1 ms tick from ClkMS, runs a random foreperiod, lights the LED and measures the response.
// Optional best-time register enabled with `define BEST_TIME_EN.
module reaction_ms_timer #(
    parameter int          CountWidth = 14,
    parameter int          MaxMs      = 9999,
    parameter int          MinDelayMs = 1000,
    parameter int          RandBits   = 11,
    parameter logic [15:0] LfsrSeed   = 16'hACE1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  ClkMS,
    input  logic                  Start,
    input  logic                  React,
    output logic                  Led,
    output logic [CountWidth-1:0] ReactMs,
    output logic                  Done,
    output logic                  FalseStart,
    output logic                  Timeout,
    output logic [CountWidth-1:0] BestMs
);

    // Wide enough for the largest foreperiod MinDelayMs + 2^RandBits - 1.
    localparam int WaitWidth = $clog2(MinDelayMs + (1 << RandBits));

    localparam logic [CountWidth-1:0] MAX_MS_C    = CountWidth'(MaxMs);
    localparam logic [CountWidth-1:0] MAX_MS_M1_C = CountWidth'(MaxMs - 1);
    localparam logic [WaitWidth-1:0]  MIN_DLY_C   = WaitWidth'(MinDelayMs);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ARMED = 3'd2,
        ST_DONE  = 3'd3,
        ST_FALSE = 3'd4
    } state_t;

    state_t                state_r;
    logic                  clkms_d_r;
    logic                  primed_r;
    logic [15:0]           lfsr_r;
    logic [WaitWidth-1:0]  wait_cnt_r;
    logic [CountWidth-1:0] ms_cnt_r;
    logic [CountWidth-1:0] react_ms_r;
    logic                  led_r;
    logic                  done_r;
    logic                  false_r;
    logic                  timeout_r;
    logic                  tick_s;
    logic [WaitWidth-1:0]  wait_load_s;

    // Fibonacci LFSR step, taps 16,14,13,11 (bit 0 is the output end).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic fb;
        fb = v[0] ^ v[2] ^ v[3] ^ v[5];
        return {fb, v[15:1]};
    endfunction

    // primed_r masks the first cycle after reset, where clkms_d_r holds no real history.
    assign tick_s      = ClkMS & ~clkms_d_r & primed_r;
    assign wait_load_s = MIN_DLY_C + WaitWidth'(lfsr_r[RandBits-1:0]);

    // Edge detector history and free-running LFSR.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            clkms_d_r <= 1'b0;
            primed_r  <= 1'b0;
            lfsr_r    <= LfsrSeed;
        end else begin
            clkms_d_r <= ClkMS;
            primed_r  <= 1'b1;
            lfsr_r    <= lfsr_next(lfsr_r);
        end
    end

    // Reaction-test sequencer with registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {WaitWidth{1'b0}};
            ms_cnt_r   <= {CountWidth{1'b0}};
            react_ms_r <= {CountWidth{1'b0}};
            led_r      <= 1'b0;
            done_r     <= 1'b0;
            false_r    <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_load_s;
                        react_ms_r <= {CountWidth{1'b0}};
                    end
                end
                ST_WAIT: begin
                    if (React) begin
                        state_r    <= ST_FALSE;
                        false_r    <= 1'b1;
                        react_ms_r <= {CountWidth{1'b0}};
                    end else if (tick_s) begin
                        if (wait_cnt_r == WaitWidth'(1)) begin
                            state_r  <= ST_ARMED;
                            ms_cnt_r <= {CountWidth{1'b0}};
                            led_r    <= 1'b1;
                        end
                        wait_cnt_r <= wait_cnt_r - WaitWidth'(1);
                    end
                end
                ST_ARMED: begin
                    // React wins over a coincident tick, so that tick is never counted.
                    if (React) begin
                        state_r    <= ST_DONE;
                        led_r      <= 1'b0;
                        done_r     <= 1'b1;
                        react_ms_r <= ms_cnt_r;
                    end else if (tick_s) begin
                        if (ms_cnt_r == MAX_MS_M1_C) begin
                            state_r    <= ST_DONE;
                            led_r      <= 1'b0;
                            done_r     <= 1'b1;
                            timeout_r  <= 1'b1;
                            react_ms_r <= MAX_MS_C;
                        end else begin
                            ms_cnt_r <= ms_cnt_r + CountWidth'(1);
                        end
                    end
                end
                ST_DONE, ST_FALSE: begin
                    if (Start) begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_load_s;
                        react_ms_r <= {CountWidth{1'b0}};
                        done_r     <= 1'b0;
                        false_r    <= 1'b0;
                        timeout_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    react_ms_r <= {CountWidth{1'b0}};
                    led_r      <= 1'b0;
                    done_r     <= 1'b0;
                    false_r    <= 1'b0;
                    timeout_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Led        = led_r;
    assign ReactMs    = react_ms_r;
    assign Done       = done_r;
    assign FalseStart = false_r;
    assign Timeout    = timeout_r;

`ifdef BEST_TIME_EN
    logic [CountWidth-1:0] best_r;

    // Best non-timeout time; loads alongside ReactMs on a React-driven DONE entry.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            best_r <= {CountWidth{1'b1}};
        end else if ((state_r == ST_ARMED) && React && (ms_cnt_r < best_r)) begin
            best_r <= ms_cnt_r;
        end else begin
            best_r <= best_r;
        end
    end

    assign BestMs = best_r;
`else
    assign BestMs = {CountWidth{1'b0}};
`endif

endmodule

// File: tb/tb_reaction_ms_timer.sv
// Randomized bench for reaction_ms_timer with a scenario-level reference model (tick counting, LFSR foreperiod, best time).
module tb_reaction_ms_timer;

    localparam int          CW    = 14;
    localparam int          MAXMS = 400;
    localparam int          MIND  = 4;
    localparam int          RB    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef BEST_TIME_EN
    localparam logic [31:0] BEST_INIT = (32'd1 << CW) - 32'd1;
`else
    localparam logic [31:0] BEST_INIT = 32'd0;
`endif

    logic          Clk   = 1'b0;
    logic          Rst_n = 1'b0;
    logic          ClkMS = 1'b0;
    logic          Start = 1'b0;
    logic          React = 1'b0;
    logic          Led;
    logic [CW-1:0] ReactMs;
    logic          Done;
    logic          FalseStart;
    logic          Timeout;
    logic [CW-1:0] BestMs;

    reaction_ms_timer #(
        .CountWidth(CW), .MaxMs(MAXMS), .MinDelayMs(MIND), .RandBits(RB), .LfsrSeed(SEED)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .ClkMS(ClkMS), .Start(Start), .React(React),
        .Led(Led), .ReactMs(ReactMs), .Done(Done), .FalseStart(FalseStart),
        .Timeout(Timeout), .BestMs(BestMs)
    );

    always #5 Clk = ~Clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_lfsr = SEED;
    bit          last_samp = 1'b0;
    bit          primed = 1'b0;
    bit          ticked = 1'b0;
    int          ph = 0;
    int          exp_wait = 0;
    logic [31:0] e_led = 0, e_done = 0, e_false = 0, e_tmo = 0, e_rms = 0;
    logic [31:0] e_best = BEST_INIT;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Polynomial x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        logic fb;
        fb = v[16-16] ^ v[16-14] ^ v[16-13] ^ v[16-11];
        return {fb, v[15:1]};
    endfunction

    function automatic bit edge_ticks();
        return ClkMS && !last_samp && primed;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; last_samp = 1'b0; primed = 1'b0; ticked = 1'b0;
    endtask

    task automatic step();
        bit t;
        t = edge_ticks();
        @(posedge Clk);
        if (!Rst_n) begin
            model_reset();
        end else begin
            ticked    = t;
            last_samp = ClkMS;
            primed    = 1'b1;
            m_lfsr    = lfsr_adv(m_lfsr);
        end
        #1;
        ph++;
        if (ph == 5) begin
            ph    = 0;
            ClkMS = ~ClkMS;
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_led"}, Led, e_led);
        chk({tag, "_done"}, Done, e_done);
        chk({tag, "_false"}, FalseStart, e_false);
        chk({tag, "_tmo"}, Timeout, e_tmo);
        chk({tag, "_rms"}, ReactMs, e_rms);
        chk({tag, "_best"}, BestMs, e_best);
    endtask

    task automatic hold_check(input int n);
        for (int i = 0; i < n; i++) begin
            React = ($urandom_range(0, 1) == 1);
            step();
            React = 1'b0;
        end
        check_outs("hold");
    endtask

    task automatic do_start(input bit with_react);
        Start    = 1'b1;
        React    = with_react;
        exp_wait = MIND + int'(m_lfsr[RB-1:0]);
        step();
        Start = 1'b0;
        React = 1'b0;
        e_led = 0; e_done = 0; e_false = 0; e_tmo = 0; e_rms = 0;
        check_outs("start");
    endtask

    task automatic go_armed();
        int nt = 0;
        bit early = 1'b0;
        while (nt < exp_wait) begin
            Start = ($urandom_range(0, 19) == 0);
            step();
            Start = 1'b0;
            if (ticked) nt++;
            if (nt < exp_wait && Led) early = 1'b1;
        end
        chk("wait_early_led", early, 0);
        chk("armed_led", Led, 1);
        chk("armed_done", Done, 0);
        e_led = 1;
    endtask

    task automatic react_armed(input int k, input bit coincide);
        int n = 0;
        bit early = 1'b0;
        while (n < k) begin
            step();
            if (ticked) n++;
            if (Done) early = 1'b1;
        end
        if (coincide) begin
            while (!edge_ticks()) step();
        end
        React = 1'b1;
        step();
        React = 1'b0;
        chk("react_early_done", early, 0);
        e_led = 0; e_done = 1; e_tmo = 0; e_rms = k;
`ifdef BEST_TIME_EN
        if (k < e_best) e_best = k;
`endif
        check_outs("react");
    endtask

    task automatic run_timeout();
        int n = 0;
        while (n < MAXMS - 1) begin
            step();
            if (ticked) n++;
        end
        chk("tmo_pre_done", Done, 0);
        chk("tmo_pre_led", Led, 1);
        do step(); while (!ticked);
        e_led = 0; e_done = 1; e_tmo = 1; e_rms = MAXMS;
        check_outs("timeout");
    endtask

    task automatic false_start(input int j, input bit at_final, input bit with_start);
        int nt = 0;
        bit early = 1'b0;
        if (at_final) begin
            while (nt < exp_wait - 1) begin
                step();
                if (ticked) nt++;
                if (Led) early = 1'b1;
            end
            while (!edge_ticks()) begin
                step();
                if (Led) early = 1'b1;
            end
        end else begin
            while (nt < j) begin
                step();
                if (ticked) nt++;
                if (Led) early = 1'b1;
            end
        end
        React = 1'b1;
        Start = with_start;
        step();
        React = 1'b0;
        Start = 1'b0;
        chk("false_early_led", early, 0);
        e_led = 0; e_done = 0; e_false = 1; e_tmo = 0; e_rms = 0;
        check_outs("false");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check_outs("reset");
        step();
        step();
        Rst_n = 1'b1;

        React = 1'b1;
        step();
        React = 1'b0;
        check_outs("idle_react");

        do_start(1'b0);
        go_armed();
        react_armed(137, 1'b0);
        hold_check(5);

        do_start(1'b1);
        false_start(exp_wait / 2, 1'b0, 1'b0);
        hold_check(4);

        do_start(1'b0);
        false_start(0, 1'b1, 1'b0);

        do_start(1'b1);
        false_start(1, 1'b0, 1'b1);

        do_start(1'b0);
        go_armed();
        react_armed(5, 1'b1);

        do_start(1'b0);
        go_armed();
        react_armed(0, 1'b0);

        do_start(1'b0);
        go_armed();
        for (int n = 0; n < 3; ) begin
            step();
            if (ticked) n++;
        end
        #3;
        Rst_n = 1'b0;
        #1;
        model_reset();
        e_led = 0; e_done = 0; e_false = 0; e_tmo = 0; e_rms = 0; e_best = BEST_INIT;
        check_outs("rst_async");
        step();
        step();
        Rst_n = 1'b1;

        do_start(1'b0);
        go_armed();
        react_armed(300, 1'b0);
        do_start(1'b0);
        go_armed();
        react_armed(150, 1'b1);
        do_start(1'b0);
        go_armed();
        react_armed(200, 1'b0);
        do_start(1'b0);
        go_armed();
        run_timeout();
        hold_check(3);

        for (int t = 0; t < 12; t++) begin
            do_start($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                false_start($urandom_range(0, exp_wait - 1), $urandom_range(0, 1) == 1,
                            $urandom_range(0, 1) == 1);
            end else begin
                go_armed();
                react_armed($urandom_range(0, 60), $urandom_range(0, 1) == 1);
            end
            hold_check($urandom_range(1, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
